mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single core memory port (read/write/be/addr/wdata in; rdata/resp back) between requester 0 (core_top) and requester 1 (program loader / debug master).
- Sits between the requesters and the memory model/BRAM controller in the emulation top.
- Round-robin grant, locked for one transaction until mem_resp. A watchdog terminates hung transactions with an error response.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum BUSY cycles without mem_resp before forced termination. Legal range is 2 or more.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the watchdog counter. Derived; not to be overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- p0_read, p0_write  in  1 each  requester 0 request strobes; held until p0_resp
- p0_addr, p0_wdata  in  32 each  requester 0 address / write data
- p0_be  in  4  requester 0 byte enables
- p0_rdata  out  32  requester 0 read data; valid only when p0_resp=1
- p0_resp  out  1  requester 0 single-cycle completion pulse
- p0_err  out  1  qualifies p0_resp: transaction timed out
- p1_read, p1_write, p1_addr, p1_wdata, p1_be, p1_rdata, p1_resp, p1_err  (same directions and widths as p0_*)  requester 1
- mem_read, mem_write  out  1 each  downstream strobes
- mem_addr, mem_wdata  out  32 each  downstream address / write data
- mem_be  out  4  downstream byte enables
- mem_rdata  in  32  downstream read data
- mem_resp  in  1  downstream completion pulse
- busy  out  1  transaction in flight
- grant  out  1  index of the current or most recent owner

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - mem_read, mem_write = 0; mem_addr, mem_wdata = 0; mem_be = 0.
  - busy = 0; grant = 1, so requester 0 wins the first contention.
  - Watchdog counter = 0.
  - All p*_resp, p*_err = 0; p*_rdata = 0.
- Request definition: reqN = pN_read | pN_write. Strobes are forwarded unchanged; the arbiter does not check for read and write both set.
- State IDLE:
  - No request: remain IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not the current grant value.
  - At the clock edge, register that requester's read, write, addr, wdata and be into the mem_* outputs, set grant, set busy, clear the watchdog, and move to BUSY.
  - Latency: request seen in cycle N gives mem_* asserted in cycle N+1.
- State BUSY:
  - mem_* outputs are held constant from the registered copy; later requester changes are ignored.
  - mem_resp=1 in cycle M:
    - Combinationally in cycle M: p[grant]_resp=1, p[grant]_rdata=mem_rdata, p[grant]_err=0.
    - At the edge: mem_read/mem_write -> 0, busy -> 0, state -> IDLE.
    - The non-granted port sees resp=0 and rdata=0.
  - No mem_resp: the watchdog increments each BUSY cycle. When it reaches TIMEOUT_CYCLES-1 in cycle T:
    - In cycle T: p[grant]_resp=1, p[grant]_err=1, p[grant]_rdata=0.
    - At the edge: strobes drop and state -> IDLE.
    - Any mem_resp arriving in IDLE afterwards is ignored.
  - mem_resp in the same cycle the watchdog expires: the normal response wins and err=0.
- Back-to-back requests:
  - Requesters deassert strobes in the cycle after their resp.
  - A strobe still high in IDLE is treated as a new request, so the minimum turnaround is 1 idle cycle between transactions.
- Fairness:
  - A continuously requesting pair alternates 0,1,0,1...
  - A lone requester is re-granted every transaction regardless of grant.
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronously), and the in-flight transaction is abandoned with no resp.
- p*_resp, p*_err and p*_rdata are combinational from state, grant, mem_resp, mem_rdata and the watchdog. All other outputs are registered.

Test Plan:
- Single read, p0 only: p0_read, addr=0x100; memory returns 0xDEADBEEF with mem_resp 3 cycles after mem_read -> mem_read rises 1 cycle after the request, mem_addr=0x100, p0_resp pulses 1 cycle with p0_rdata=0xDEADBEEF, p1_resp=0, busy falls next cycle.
- Simultaneous requests after reset: p0_write (addr 0x10, wdata 0x11223344, be=0xF) and p1_read (addr 0x20) in the same cycle -> p0 served first (grant=0, mem_write=1, mem_be=0xF), then p1 (grant=1, mem_addr=0x20); p1 waits unchanged.
- Continuous contention over 6 transactions -> grant sequence 0,1,0,1,0,1; no requester is granted twice in a row while the other waits.
- Timeout with TIMEOUT_CYCLES=8: p1_read and mem_resp never asserted -> p1_resp=1, p1_err=1, p1_rdata=0 exactly 8 BUSY cycles after mem_read rose; mem_read=0 the following cycle; a late mem_resp is ignored.
- Request-hold isolation: change p0_addr from 0x40 to 0x80 during BUSY -> mem_addr stays 0x40 until resp.
- Reset mid-transaction: assert rst_n=0 while BUSY -> mem_read, busy drop asynchronously (before the next clk edge); after release, a p0 request is granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the shared core memory port.
// The grant is held for one whole transaction; a watchdog ends a hung transaction with an error response.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_read,
    input  logic        p0_write,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_be,
    output logic [31:0] p0_rdata,
    output logic        p0_resp,
    output logic        p0_err,

    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_be,
    output logic [31:0] p1_rdata,
    output logic        p1_resp,
    output logic        p1_err,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,

    output logic        busy,
    output logic        grant
);

    localparam int unsigned     CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;

    logic req0, req1, wdog_expired;

    assign req0         = p0_read | p0_write;
    assign req1         = p1_read | p1_write;
    assign wdog_expired = (wdog_q == WDOG_LAST);

    // State and registered mem-side copy of the granted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b1;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wdog_q      <= wdog_d;
        end
    end

    always_comb begin
        logic pick;
        logic done;
        pick        = 1'b0;
        done        = 1'b0;
        state_d     = state_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wdog_d      = wdog_q;
        p0_resp     = 1'b0;
        p0_err      = 1'b0;
        p0_rdata    = '0;
        p1_resp     = 1'b0;
        p1_err      = 1'b0;
        p1_rdata    = '0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to whoever did not hold the last grant
                    pick        = (req0 && req1) ? ~grant_q : req1;
                    grant_d     = pick;
                    mem_read_d  = pick ? p1_read  : p0_read;
                    mem_write_d = pick ? p1_write : p0_write;
                    mem_addr_d  = pick ? p1_addr  : p0_addr;
                    mem_wdata_d = pick ? p1_wdata : p0_wdata;
                    mem_be_d    = pick ? p1_be    : p0_be;
                    busy_d      = 1'b1;
                    wdog_d      = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                done = mem_resp || wdog_expired;
                if (done) begin
                    // A real response beats a coincident timeout
                    if (grant_q) begin
                        p1_resp  = 1'b1;
                        p1_err   = ~mem_resp;
                        p1_rdata = mem_resp ? mem_rdata : 32'h0;
                    end else begin
                        p0_resp  = 1'b1;
                        p0_err   = ~mem_resp;
                        p0_rdata = mem_resp ? mem_rdata : 32'h0;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = busy_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_resp, p0_err, p1_resp, p1_err;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_resp;
    logic        busy, grant;

    int tests = 0;
    int fails = 0;
    int last_grant;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_read(p0_read), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_be(p0_be), .p0_rdata(p0_rdata), .p0_resp(p0_resp), .p0_err(p0_err),
        .p1_read(p1_read), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_be(p1_be), .p1_rdata(p1_rdata), .p1_resp(p1_resp), .p1_err(p1_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            p0_read = rd; p0_write = ~rd; p0_addr = a; p0_wdata = d; p0_be = be;
        end else begin
            p1_read = rd; p1_write = ~rd; p1_addr = a; p1_wdata = d; p1_be = be;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        p0_read = 0; p0_write = 0; p1_read = 0; p1_write = 0;
        p0_addr = 0; p0_wdata = 0; p0_be = 0;
        p1_addr = 0; p1_wdata = 0; p1_be = 0;
        mem_resp = 0; mem_rdata = 32'hBAD0_BAD0;
        tick(); tick();
        rst_n = 1'b1;
        last_grant = 1;
        tick();
    endtask

    // One transaction from the requests currently driven; memory answers after lat busy cycles
    task automatic serve(input int lat, input logic [31:0] rd);
        int w;
        logic q0, q1, er, ew;
        logic [31:0] ea, ed;
        logic [3:0] eb;
        q0 = p0_read | p0_write;
        q1 = p1_read | p1_write;
        if (q0 && q1) w = 1 - last_grant;
        else          w = q1 ? 1 : 0;
        er = (w == 1) ? p1_read  : p0_read;
        ew = (w == 1) ? p1_write : p0_write;
        ea = (w == 1) ? p1_addr  : p0_addr;
        ed = (w == 1) ? p1_wdata : p0_wdata;
        eb = (w == 1) ? p1_be    : p0_be;
        chk("idle_mem_read", 32'(mem_read), 32'd0);
        tick();
        chk("grant", 32'(grant), 32'(w));
        chk("busy_set", 32'(busy), 32'd1);
        chk("mem_read", 32'(mem_read), 32'(er));
        chk("mem_write", 32'(mem_write), 32'(ew));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("mem_be", 32'(mem_be), 32'(eb));
        last_grant = w;
        // The granted requester wiggles its payload; mem side must not follow
        if (w == 1) begin p1_addr ^= 32'hC0; p1_wdata = ~p1_wdata; end
        else        begin p0_addr ^= 32'hC0; p0_wdata = ~p0_wdata; end
        for (int i = 0; i < lat; i++) begin
            mem_rdata = $urandom;
            #1;
            chk("early_resp0", 32'(p0_resp), 32'd0);
            chk("early_resp1", 32'(p1_resp), 32'd0);
            tick();
            chk("hold_addr", mem_addr, ea);
            chk("hold_read", 32'(mem_read), 32'(er));
        end
        mem_resp = 1'b1;
        mem_rdata = rd;
        #1;
        chk("resp_win", 32'(w == 1 ? p1_resp : p0_resp), 32'd1);
        chk("rdata_win", (w == 1) ? p1_rdata : p0_rdata, rd);
        chk("err_win", 32'(w == 1 ? p1_err : p0_err), 32'd0);
        chk("resp_lose", 32'(w == 1 ? p0_resp : p1_resp), 32'd0);
        chk("rdata_lose", (w == 1) ? p0_rdata : p1_rdata, 32'd0);
        tick();
        mem_resp = 1'b0;
        mem_rdata = $urandom;
        if (w == 1) begin p1_read = 0; p1_write = 0; end
        else        begin p0_read = 0; p0_write = 0; end
        chk("busy_clr", 32'(busy), 32'd0);
        chk("strobe_clr", 32'({mem_read, mem_write}), 32'd0);
    endtask

    initial begin
        apply_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd1);
        chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_resp", 32'({p0_resp, p0_err, p1_resp, p1_err}), 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);

        // Single read from requester 0
        set_req(0, 1'b1, 32'h100, 32'h0, 4'hF);
        serve(3, 32'hDEADBEEF);

        // Simultaneous requests right after reset
        apply_reset();
        set_req(0, 1'b0, 32'h10, 32'h11223344, 4'hF);
        set_req(1, 1'b1, 32'h20, 32'h0, 4'h3);
        serve(2, 32'h0);
        chk("p1_waiting_addr", p1_addr, 32'h20);
        serve(1, 32'hCAFEF00D);

        // Continuous contention alternates 0,1,0,1,...
        apply_reset();
        set_req(0, 1'b1, 32'h1000, 32'h0, 4'hF);
        set_req(1, 1'b1, 32'h2000, 32'h0, 4'hF);
        for (int k = 0; k < 6; k++) begin
            serve(k % 3, $urandom);
            chk("contend_seq", 32'(grant), 32'(k % 2));
            set_req(k % 2, 1'b1, 32'h1000 + 32'(k), 32'h0, 4'hF);
        end
        p0_read = 0; p1_read = 0;
        tick();

        // Watchdog timeout on requester 1
        set_req(1, 1'b1, 32'h300, 32'h0, 4'hF);
        tick();
        chk("to_grant", 32'(grant), 32'd1);
        last_grant = 1;
        for (int i = 0; i < int'(TO); i++) begin
            mem_rdata = 32'h5555AAAA;
            #1;
            chk("to_mem_read", 32'(mem_read), 32'd1);
            chk("to_resp", 32'(p1_resp), 32'(i == int'(TO) - 1));
            chk("to_resp0", 32'(p0_resp), 32'd0);
            if (i == int'(TO) - 1) begin
                chk("to_err", 32'(p1_err), 32'd1);
                chk("to_rdata", p1_rdata, 32'd0);
            end
            tick();
        end
        chk("to_read_drop", 32'(mem_read), 32'd0);
        chk("to_busy_drop", 32'(busy), 32'd0);
        p1_read = 0;
        mem_resp = 1'b1;
        #1;
        chk("late_resp1", 32'(p1_resp), 32'd0);
        chk("late_resp0", 32'(p0_resp), 32'd0);
        tick();
        mem_resp = 1'b0;
        chk("late_busy", 32'(busy), 32'd0);

        // Payload hold while busy (0x40 is perturbed to 0x80 inside serve)
        set_req(0, 1'b1, 32'h40, 32'h0, 4'h1);
        serve(4, 32'h12345678);

        // Response in the same cycle the watchdog expires wins
        set_req(1, 1'b0, 32'h500, 32'hA5A5A5A5, 4'hC);
        serve(int'(TO) - 1, 32'h0BADCAFE);

        // Reset mid-transaction
        set_req(1, 1'b1, 32'h600, 32'h0, 4'hF);
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_read", 32'(mem_read), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_grant", 32'(grant), 32'd1);
        chk("arst_resp", 32'(p1_resp), 32'd0);
        p1_read = 0;
        tick();
        rst_n = 1'b1;
        last_grant = 1;
        tick();
        set_req(0, 1'b1, 32'h700, 32'h0, 4'hF);
        set_req(1, 1'b1, 32'h800, 32'h0, 4'hF);
        serve(1, $urandom);
        chk("post_rst_first", 32'(grant), 32'd0);
        serve(0, $urandom);

        // Randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            logic has0, has1;
            has0 = p0_read | p0_write;
            has1 = p1_read | p1_write;
            if (!has0 && ($urandom_range(0, 1) == 1))
                set_req(0, 1'($urandom), $urandom, $urandom, 4'($urandom));
            if (!has1 && ($urandom_range(0, 1) == 1))
                set_req(1, 1'($urandom), $urandom, $urandom, 4'($urandom));
            if (!(p0_read | p0_write | p1_read | p1_write))
                set_req(int'($urandom_range(0, 1)), 1'($urandom), $urandom, $urandom, 4'($urandom));
            serve(int'($urandom_range(0, int'(TO) - 2)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
